// File: rtl/lstm_step_sequencer_pkg.sv
// Shared definitions for the LSTM back pipeline: controller state encodings and
// the node latency constant that the node datapath and the step sequencer must agree on.
package lstm_step_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_GATE   = 3'd2,
    S_NODE   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_MAC  = 2'd1,
    PE_OUT  = 2'd2
  } pe_state_t;

  typedef enum logic [1:0] {
    LSTM_IDLE = 2'd0,
    LSTM_RUN  = 2'd1,
    LSTM_OUT  = 2'd2
  } lstm_state_t;

  localparam int SEQ_W_DEF    = 8;
  localparam int NODE_LAT_DEF = 4;
  localparam int PE_TMO_DEF   = 16;

endpackage

// File: rtl/lstm_step_sequencer_watchdog.sv
// PE-pass watchdog: reloaded on GATE entry, counts GATE cycles, flags all-ones.
// The load value of 1 accounts for the entry cycle itself, so the flag rises on GATE cycle 2**W-1.
module lstm_step_watchdog #(
  parameter int W = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [W-1:0] LOAD_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + LOAD_VAL;
    end
  end

  assign o_tc = &r_cnt;

endmodule

// File: rtl/lstm_step_sequencer.sv
// Timestep controller: per step fetch x_t, launch the gate MACs, run the node pipeline,
// write h_t/c_t back; outputs are registered from the next state (x_ready decodes state).
module lstm_step_sequencer
  import lstm_step_sequencer_pkg::*;
#(
  parameter int SEQ_W    = SEQ_W_DEF,
  parameter int NODE_LAT = NODE_LAT_DEF,
  parameter int PE_TMO   = PE_TMO_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [SEQ_W-1:0] i_seq_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  input  logic             i_x_valid,
  output logic             o_x_ready,
  output logic             o_pe_start,
  input  logic             i_pe_done,
  output logic             o_node_en,
  output logic             o_recu_clr,
  output logic             o_recu_we,
  output logic             o_out_we,
  output logic [SEQ_W-1:0] o_t_idx
);

  localparam int               NC_W      = (NODE_LAT > 1) ? $clog2(NODE_LAT) : 1;
  localparam logic [NC_W-1:0]  NODE_LAST = NC_W'(NODE_LAT - 1);
  localparam logic [NC_W-1:0]  NC_ONE    = {{(NC_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] T_ONE     = {{(SEQ_W-1){1'b0}}, 1'b1};

  seq_state_t       r_state, w_state_nxt;
  logic [SEQ_W-1:0] r_seq_len, r_t_idx;
  logic [NC_W-1:0]  r_node_cnt;
  logic             r_err, r_busy, r_done, r_pe_start, r_node_en, r_recu_clr, r_wb;
  logic             w_busy_d, w_done_d, w_pe_start_d, w_node_en_d, w_recu_clr_d, w_wb_d;
  logic             w_start_acc, w_last, w_wd_load, w_wd_en, w_wd_tc, w_timeout;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_last      = (r_t_idx == (r_seq_len - T_ONE));
  assign w_wd_load   = (w_state_nxt == S_GATE) && (r_state != S_GATE);
  assign w_wd_en     = (r_state == S_GATE);
  // pe_done wins a tie with the watchdog: a late-but-present result is still used
  assign w_timeout   = (r_state == S_GATE) && !i_pe_done && w_wd_tc;

  lstm_step_watchdog #(.W(PE_TMO)) u_watchdog (
    .i_clk   (i_clock),
    .i_reset (i_reset),
    .i_load  (w_wd_load),
    .i_en    (w_wd_en),
    .o_tc    (w_wd_tc)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_LOAD_X;
      S_LOAD_X: if (i_x_valid) w_state_nxt = S_GATE;
      S_GATE: begin
        if (i_pe_done)    w_state_nxt = S_NODE;
        else if (w_wd_tc) w_state_nxt = S_DONE;
      end
      S_NODE:   if (r_node_cnt == NODE_LAST) w_state_nxt = S_WB;
      S_WB:     w_state_nxt = w_last ? S_DONE : S_LOAD_X;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_d     = (w_state_nxt != S_IDLE);
    w_done_d     = (w_state_nxt == S_DONE);
    w_pe_start_d = (w_state_nxt == S_GATE) && (r_state != S_GATE);
    w_node_en_d  = (w_state_nxt == S_NODE) && (r_state != S_NODE);
    w_recu_clr_d = (w_state_nxt == S_NODE) && (r_t_idx == '0);
    w_wb_d       = (w_state_nxt == S_WB);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pe_start <= 1'b0;
      r_node_en  <= 1'b0;
      r_recu_clr <= 1'b0;
      r_wb       <= 1'b0;
    end else begin
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_pe_start <= w_pe_start_d;
      r_node_en  <= w_node_en_d;
      r_recu_clr <= w_recu_clr_d;
      r_wb       <= w_wb_d;
    end
  end

  // Last step is detected before increment, so t_idx never wraps at seq_len=255
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_seq_len  <= '0;
      r_t_idx    <= '0;
      r_err      <= 1'b0;
      r_node_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_seq_len <= (i_seq_len == '0) ? T_ONE : i_seq_len;
        r_t_idx   <= '0;
        r_err     <= 1'b0;
      end else begin
        if ((r_state == S_WB) && !w_last) r_t_idx <= r_t_idx + T_ONE;
        if (w_timeout)                    r_err   <= 1'b1;
      end
      r_node_cnt <= (r_state == S_NODE) ? (r_node_cnt + NC_ONE) : '0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_x_ready  = (r_state == S_LOAD_X);
  assign o_pe_start = r_pe_start;
  assign o_node_en  = r_node_en;
  assign o_recu_clr = r_recu_clr;
  assign o_recu_we  = r_wb;
  assign o_out_we   = r_wb;
  assign o_t_idx    = r_t_idx;

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Bench for lstm_step_sequencer: expected pe_start/node_en/writeback/done events are queued
// at start time and matched, with cycle stamps, as the DUT emits them.
module tb_lstm_step_sequencer;
  import lstm_step_sequencer_pkg::*;

  localparam int SEQ_W = 8;
  localparam int NL    = NODE_LAT_DEF;
  localparam int TMO   = 8;
  localparam int P     = 2;
  localparam int L     = 3 + NL + P;
  localparam int K_PE = 0, K_NODE = 1, K_WB = 2, K_DONE = 3;

  typedef struct {int k; int t; int c; int f;} ev_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1, start = 1'b0, x_valid = 1'b1;
  logic             pe_auto_done = 1'b0, pe_stray = 1'b0;
  logic [SEQ_W-1:0] seq_len = '0;
  logic             w_pe_done;
  logic             o_busy, o_done, o_err, o_x_ready, o_pe_start, o_node_en;
  logic             o_recu_clr, o_recu_we, o_out_we;
  logic [SEQ_W-1:0] o_t_idx;

  ev_t   exp_q[$];
  ev_t   mon_q[$];
  ev_t   mo, me;
  int    cyc = 0, vectors = 0, miscompares = 0;
  int    pe_cd = 0, n_clr = 0, n_done = 0;
  bit    pe_auto = 1'b1;
  string cur_test = "reset";

  assign w_pe_done = pe_auto_done | pe_stray;

  lstm_step_sequencer #(.SEQ_W(SEQ_W), .NODE_LAT(NL), .PE_TMO(TMO)) dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_seq_len(seq_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .i_x_valid(x_valid), .o_x_ready(o_x_ready), .o_pe_start(o_pe_start),
    .i_pe_done(w_pe_done), .o_node_en(o_node_en), .o_recu_clr(o_recu_clr),
    .o_recu_we(o_recu_we), .o_out_we(o_out_we), .o_t_idx(o_t_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PE array model: pe_done pulses P cycles after each pe_start
  always @(posedge clk) begin
    #1;
    pe_auto_done = 1'b0;
    if (pe_cd > 0) begin
      pe_cd = pe_cd - 1;
      if (pe_cd == 0) pe_auto_done = 1'b1;
    end
    if (o_pe_start && pe_auto) pe_cd = P;
  end

  function automatic ev_t mk(input int k, input int t, input int c, input int f);
    ev_t e;
    e.k = k; e.t = t; e.c = c; e.f = f;
    return e;
  endfunction

  always @(negedge clk) begin
    if (o_pe_start) mon_q.push_back(mk(K_PE, int'(o_t_idx), cyc, int'(o_x_ready)));
    if (o_node_en)  mon_q.push_back(mk(K_NODE, int'(o_t_idx), cyc, int'(o_recu_clr)));
    if (o_recu_we || o_out_we) mon_q.push_back(mk(K_WB, int'(o_t_idx), cyc, int'(o_recu_we & o_out_we)));
    if (o_done) begin
      mon_q.push_back(mk(K_DONE, int'(o_t_idx), cyc, int'({o_busy, o_err})));
      n_done = n_done + 1;
    end
    if (o_recu_clr) n_clr = n_clr + 1;
    while (mon_q.size() > 0) begin
      mo = mon_q.pop_front();
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: unexpected event kind=%0d t=%0d cyc=%0d f=%0d", cur_test, mo.k, mo.t, mo.c, mo.f);
      end else begin
        me = exp_q.pop_front();
        if (mo.k !== me.k || mo.t !== me.t || mo.c !== me.c || mo.f !== me.f) begin
          miscompares = miscompares + 1;
          $display("FAIL %s: event got kind=%0d t=%0d cyc=%0d f=%0d, want kind=%0d t=%0d cyc=%0d f=%0d",
                   cur_test, mo.k, mo.t, mo.c, mo.f, me.k, me.t, me.c, me.f);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, output int s);
    tick();
    exp_q.delete();
    n_clr  = 0;
    n_done = 0;
    start   = 1'b1;
    seq_len = SEQ_W'(n);
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  // Expected events of a complete run; `stall` extra LOAD_X cycles are spent in step stall_step
  task automatic push_run(input int s, input int n, input int stall_step, input int stall, input int err);
    int ne, off, pc;
    ne = (n == 0) ? 1 : n;
    for (int j = 0; j < ne; j++) begin
      off = (j >= stall_step) ? stall : 0;
      pc  = s + 2 + j * L + off;
      exp_q.push_back(mk(K_PE, j, pc, 0));
      exp_q.push_back(mk(K_NODE, j, pc + 1 + P, (j == 0) ? 1 : 0));
      exp_q.push_back(mk(K_WB, j, pc + 1 + P + NL, 1));
    end
    exp_q.push_back(mk(K_DONE, ne - 1, s + 1 + ne * L + stall, 2 + err));
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i = i + 1;
    end while (!o_done && i < budget);
    if (!o_done) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s: no done within %0d cycles", cur_test, budget);
    end
    tick();
  endtask

  task automatic test_reset();
    cur_test = "reset";
    repeat (3) tick();
    @(negedge clk);
    vectors = vectors + 1;
    if ({o_busy, o_done, o_err, o_x_ready, o_pe_start, o_node_en, o_recu_clr, o_recu_we, o_out_we, o_t_idx} !== '0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_outputs: got busy=%b err=%b t_idx=%0d, want all zero", o_busy, o_err, o_t_idx);
    end
    tick();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    vectors = vectors + 1;
    if (o_busy !== 1'b0 || o_x_ready !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL idle_after_reset: busy=%b x_ready=%b, want 0 0", o_busy, o_x_ready);
    end
  endtask

  task automatic test_basic(input int n, input string nm);
    int s;
    cur_test = nm;
    do_start(n, s);
    push_run(s, n, 0, 0, 0);
    wait_done(((n == 0) ? 1 : n) * L + 20);
    vectors = vectors + 1;
    if (exp_q.size() != 0 || n_done != 1 || n_clr != NL) begin
      miscompares = miscompares + 1;
      $display("FAIL %s_totals: left=%0d done=%0d clr_cycles=%0d, want 0 1 %0d", nm, exp_q.size(), n_done, n_clr, NL);
    end
  endtask

  task automatic test_x_stall();
    int s;
    cur_test = "x_stall";
    do_start(3, s);
    push_run(s, 3, 1, 5, 0);
    while (cyc < s + 1 + L) tick();
    x_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors = vectors + 1;
      if (o_x_ready !== 1'b1 || o_pe_start !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL x_stall_hold: x_ready=%b pe_start=%b, want 1 0", o_x_ready, o_pe_start);
      end
      tick();
    end
    x_valid = 1'b1;
    wait_done(3 * L + 30);
    vectors = vectors + 1;
    if (exp_q.size() != 0 || n_done != 1) begin
      miscompares = miscompares + 1;
      $display("FAIL x_stall_totals: left=%0d done=%0d, want 0 1", exp_q.size(), n_done);
    end
  endtask

  task automatic test_busy_start();
    int s;
    cur_test = "busy_start";
    do_start(2, s);
    push_run(s, 2, 0, 0, 0);
    while (cyc < s + 5) tick();
    start = 1'b1;
    seq_len = 8'd7;
    tick();
    start = 1'b0;
    while (cyc < s + 1 + L) tick();
    pe_stray = 1'b1;
    tick();
    pe_stray = 1'b0;
    wait_done(2 * L + 20);
    vectors = vectors + 1;
    if (exp_q.size() != 0 || n_done != 1) begin
      miscompares = miscompares + 1;
      $display("FAIL busy_start_totals: left=%0d done=%0d, want 0 1", exp_q.size(), n_done);
    end
  endtask

  task automatic test_timeout();
    int s;
    cur_test = "timeout";
    pe_auto = 1'b0;
    do_start(2, s);
    exp_q.push_back(mk(K_PE, 0, s + 2, 0));
    exp_q.push_back(mk(K_DONE, 0, s + 2 + (1 << TMO) - 1, 3));
    wait_done((1 << TMO) + 20);
    @(negedge clk);
    vectors = vectors + 1;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL timeout_sticky: err=%b busy=%b left=%0d, want 1 0 0", o_err, o_busy, exp_q.size());
    end
    pe_auto = 1'b1;
    cur_test = "after_timeout";
    do_start(2, s);
    push_run(s, 2, 0, 0, 0);
    @(negedge clk);
    vectors = vectors + 1;
    if (o_err !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL err_clear: err=%b, want 0", o_err);
    end
    wait_done(2 * L + 20);
  endtask

  task automatic test_reset_abort();
    int s;
    cur_test = "reset_abort";
    do_start(3, s);
    push_run(s, 3, 0, 0, 0);
    while (cyc < s + 2 + 2 * L + 1 + P + 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors = vectors + 1;
    if ({o_busy, o_done, o_err, o_x_ready, o_pe_start, o_node_en, o_recu_clr, o_recu_we, o_out_we, o_t_idx} !== '0) begin
      miscompares = miscompares + 1;
      $display("FAIL abort_outputs: busy=%b done=%b recu_clr=%b t_idx=%0d, want all zero", o_busy, o_done, o_recu_clr, o_t_idx);
    end
    repeat (40) tick();
    vectors = vectors + 1;
    if (n_done != 0 || exp_q.size() != 2) begin
      miscompares = miscompares + 1;
      $display("FAIL abort_no_done: done=%0d left=%0d, want 0 2", n_done, exp_q.size());
    end
    exp_q.delete();
    test_basic(3, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic(3, "basic_len3");
    test_basic(0, "zero_len");
    test_x_stall();
    test_busy_start();
    test_timeout();
    test_reset_abort();
    test_basic(255, "max_len");
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
